lane_phase_scheduler: RTL and testbench



---
 rtl/lane_phase_scheduler_pkg.sv | 24 ++
 rtl/lane_phase_scheduler_rr_lane_picker.sv | 29 ++
 rtl/lane_phase_scheduler.sv | 170 +++++++++++++++++
 tb/tb_lane_phase_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_phase_scheduler_pkg.sv
// Shared encodings for the intersection phase scheduler: controller modes,
// FSM phase codes and per-lane light patterns.
package lane_phase_scheduler_pkg;

    localparam logic [1:0] MODE_LOAD  = 2'b00;
    localparam logic [1:0] MODE_RED   = 2'b01;
    localparam logic [1:0] MODE_SCHED = 2'b10;

    typedef enum logic [2:0] {
        ST_HOLD_RED = 3'd0,
        ST_ARB      = 3'd1,
        ST_GREEN    = 3'd2,
        ST_YELLOW   = 3'd3,
        ST_CLEAR    = 3'd4
    } phase_e;

    localparam logic [3:0] LIGHTS_ALL  = 4'b1111;
    localparam logic [3:0] LIGHTS_NONE = 4'b0000;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/lane_phase_scheduler_rr_lane_picker.sv
// Combinational round-robin pick: first lane after last_served (wrapping,
// last_served itself checked last) whose nonzero bit is set.
module rr_lane_picker (
    input  logic [3:0] nonzero_mask_i,
    input  logic [1:0] last_served_i,
    output logic       found_o,
    output logic [1:0] index_o
);

    logic [1:0] cand [4];
    logic [3:0] hit;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand[gi] = last_served_i + 2'(gi + 1);
        assign hit[gi]  = nonzero_mask_i[cand[gi]];
    end

    // Walk from the lowest search distance last so it wins.
    always_comb begin
        found_o = |hit;
        index_o = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (hit[k]) begin
                index_o = cand[k];
            end
        end
    end

endmodule

// File: rtl/lane_phase_scheduler.sv
// Four-lane phase sequencer for scheduled mode: round-robin green grants,
// yellow and all-red clearance, and one-car decrement requests.
module lane_phase_scheduler
    import lane_phase_scheduler_pkg::*;
#(
    parameter int COUNT_W      = 4,
    parameter int GREEN_MAX    = 6,
    parameter int YELLOW_TICKS = 2,
    parameter int CLEAR_TICKS  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [1:0]           mode,
    input  logic [4*COUNT_W-1:0] lane_count,
    output logic [3:0]           light_red,
    output logic [3:0]           light_yellow,
    output logic [3:0]           light_green,
    output logic                 dec_en,
    output logic [1:0]           dec_sel,
    output logic [2:0]           phase
);

    localparam int TIMER_W = 8;
    localparam logic [TIMER_W-1:0] GREEN_LAST  = TIMER_W'(GREEN_MAX);
    localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_TICKS);
    localparam logic [TIMER_W-1:0] CLEAR_LAST  = TIMER_W'(CLEAR_TICKS);

    phase_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
    logic [1:0]         cur_lane_q, cur_lane_d;
    logic [1:0]         last_served_q, last_served_d;
    logic               dec_en_q, dec_d;
    logic [1:0]         dec_sel_q;
    logic [3:0]         red_q, red_d, yellow_q, yellow_d, green_q, green_d;

    logic [3:0] lane_nz;
    logic       sched;
    logic       pick_found;
    logic [1:0] pick_idx;

    for (genvar gi = 0; gi < 4; gi++) begin : g_nz
        assign lane_nz[gi] = |lane_count[gi*COUNT_W +: COUNT_W];
    end

    assign sched     = (mode == MODE_SCHED);
    assign timer_inc = timer_q + TIMER_W'(1);

    rr_lane_picker u_picker (
        .nonzero_mask_i (lane_nz),
        .last_served_i  (last_served_q),
        .found_o        (pick_found),
        .index_o        (pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cur_lane_d    = cur_lane_q;
        last_served_d = last_served_q;
        dec_d         = 1'b0;
        if (tick) begin
            case (state_q)
                ST_HOLD_RED: begin
                    if (sched) begin
                        state_d = ST_CLEAR;
                        timer_d = '0;
                    end
                end
                ST_CLEAR: begin
                    if (!sched) begin
                        state_d = ST_HOLD_RED;
                        timer_d = '0;
                    end else if (timer_inc == CLEAR_LAST) begin
                        state_d = ST_ARB;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                ST_ARB: begin
                    if (!sched) begin
                        state_d = ST_HOLD_RED;
                        timer_d = '0;
                    end else if (pick_found) begin
                        state_d    = ST_GREEN;
                        cur_lane_d = pick_idx;
                        timer_d    = '0;
                    end
                end
                ST_GREEN: begin
                    // Leaving scheduled mode or an emptied lane still passes through yellow.
                    if (!sched || !lane_nz[cur_lane_q]) begin
                        state_d       = ST_YELLOW;
                        timer_d       = '0;
                        last_served_d = cur_lane_q;
                    end else begin
                        dec_d = 1'b1;
                        if (timer_inc == GREEN_LAST) begin
                            state_d       = ST_YELLOW;
                            timer_d       = '0;
                            last_served_d = cur_lane_q;
                        end else begin
                            timer_d = timer_inc;
                        end
                    end
                end
                ST_YELLOW: begin
                    if (timer_inc == YELLOW_LAST) begin
                        state_d = sched ? ST_CLEAR : ST_HOLD_RED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                default: begin
                    state_d = ST_HOLD_RED;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        red_d    = LIGHTS_ALL;
        yellow_d = LIGHTS_NONE;
        green_d  = LIGHTS_NONE;
        if (state_d == ST_GREEN) begin
            green_d = lane_onehot(cur_lane_d);
            red_d   = ~green_d;
        end else if (state_d == ST_YELLOW) begin
            yellow_d = lane_onehot(cur_lane_d);
            red_d    = ~yellow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_HOLD_RED;
            timer_q       <= '0;
            cur_lane_q    <= 2'd0;
            last_served_q <= 2'd3;
            dec_en_q      <= 1'b0;
            dec_sel_q     <= 2'd0;
            red_q         <= LIGHTS_ALL;
            yellow_q      <= LIGHTS_NONE;
            green_q       <= LIGHTS_NONE;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cur_lane_q    <= cur_lane_d;
            last_served_q <= last_served_d;
            dec_en_q      <= dec_d;
            if (dec_d) begin
                dec_sel_q <= cur_lane_q;
            end
            red_q         <= red_d;
            yellow_q      <= yellow_d;
            green_q       <= green_d;
        end
    end

    assign light_red    = red_q;
    assign light_yellow = yellow_q;
    assign light_green  = green_q;
    assign dec_en       = dec_en_q;
    assign dec_sel      = dec_sel_q;
    assign phase        = state_q;

endmodule

// File: tb/tb_lane_phase_scheduler.sv
// Scoreboard bench for lane_phase_scheduler: a tick-level reference model
// pushes expected outputs per tick, compared one clock after the tick edge.
module tb_lane_phase_scheduler;
    import lane_phase_scheduler_pkg::*;

    localparam int COUNT_W      = 4;
    localparam int GREEN_MAX    = 6;
    localparam int YELLOW_TICKS = 2;
    localparam int CLEAR_TICKS  = 1;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 tick  = 1'b0;
    logic [1:0]           mode  = MODE_LOAD;
    logic [4*COUNT_W-1:0] lane_count = '0;
    logic [3:0]           light_red, light_yellow, light_green;
    logic                 dec_en;
    logic [1:0]           dec_sel;
    logic [2:0]           phase;

    lane_phase_scheduler #(
        .COUNT_W      (COUNT_W),
        .GREEN_MAX    (GREEN_MAX),
        .YELLOW_TICKS (YELLOW_TICKS),
        .CLEAR_TICKS  (CLEAR_TICKS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .mode         (mode),
        .lane_count   (lane_count),
        .light_red    (light_red),
        .light_yellow (light_yellow),
        .light_green  (light_green),
        .dec_en       (dec_en),
        .dec_sel      (dec_sel),
        .phase        (phase)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] phase;
        logic [3:0] red;
        logic [3:0] yellow;
        logic [3:0] green;
        logic       dec;
        logic [1:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   tick_no     = 0;

    // Reference model state (lane counts model the register file).
    int   m_state, m_timer, m_cur, m_last;
    int   m_cnt[4];
    bit   hold_counts;

    int   dec_seen, g1_seen;
    bit   any_green;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive_counts();
        for (int i = 0; i < 4; i++) begin
            lane_count[i*COUNT_W +: COUNT_W] = COUNT_W'(m_cnt[i]);
        end
    endtask

    task automatic model_step(output exp_t e);
        bit sched;
        int l;
        sched = (mode == MODE_SCHED);
        e = '0;
        case (m_state)
            0: if (sched) begin m_state = 4; m_timer = 0; end
            4: begin
                if (!sched) begin m_state = 0; m_timer = 0; end
                else if (m_timer + 1 == CLEAR_TICKS) begin m_state = 1; m_timer = 0; end
                else m_timer++;
            end
            1: begin
                if (!sched) m_state = 0;
                else begin
                    for (int k = 1; k <= 4; k++) begin
                        l = (m_last + k) % 4;
                        if (m_state == 1 && m_cnt[l] != 0) begin
                            m_cur = l; m_state = 2; m_timer = 0;
                        end
                    end
                end
            end
            2: begin
                if (!sched || m_cnt[m_cur] == 0) begin
                    m_state = 3; m_timer = 0; m_last = m_cur;
                end else begin
                    e.dec = 1'b1;
                    e.sel = 2'(m_cur);
                    if (m_timer + 1 == GREEN_MAX) begin
                        m_state = 3; m_timer = 0; m_last = m_cur;
                    end else m_timer++;
                end
            end
            3: begin
                if (m_timer + 1 == YELLOW_TICKS) begin
                    m_state = sched ? 4 : 0; m_timer = 0;
                end else m_timer++;
            end
            default: ;
        endcase
        e.phase  = 3'(m_state);
        e.red    = 4'hF;
        e.yellow = 4'h0;
        e.green  = 4'h0;
        if (m_state == 2) begin
            e.green = 4'(1 << m_cur);
            e.red   = ~e.green;
        end else if (m_state == 3) begin
            e.yellow = 4'(1 << m_cur);
            e.red    = ~e.yellow;
        end
    endtask

    task automatic do_tick(input string note);
        exp_t e;
        @(negedge clock);
        tick = 1'b1;
        model_step(e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        tick = 1'b0;
        tick_no++;
        e = exp_q.pop_front();
        check_eq({note, "/phase"},  32'(phase),        32'(e.phase));
        check_eq({note, "/red"},    32'(light_red),    32'(e.red));
        check_eq({note, "/yellow"}, 32'(light_yellow), 32'(e.yellow));
        check_eq({note, "/green"},  32'(light_green),  32'(e.green));
        check_eq({note, "/dec_en"}, 32'(dec_en),       32'(e.dec));
        if (e.dec) check_eq({note, "/dec_sel"}, 32'(dec_sel), 32'(e.sel));
        $display("tick %0d %s: phase=%0d R=%b Y=%b G=%b dec_en=%b dec_sel=%0d counts=%0d/%0d/%0d/%0d",
                 tick_no, note, phase, light_red, light_yellow, light_green, dec_en, dec_sel,
                 m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
        if (dec_en) dec_seen++;
        if (light_green[1]) g1_seen++;
        if (|light_green) any_green = 1'b1;
        if (e.dec && !hold_counts) begin
            m_cnt[e.sel]--;
            drive_counts();
        end
        @(posedge clock);
        #1;
        check_eq({note, "/dec_pulse"},  32'(dec_en), 32'(0));
        check_eq({note, "/phase_hold"}, 32'(phase),  32'(e.phase));
        repeat (2) @(posedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("rst/phase",   32'(phase),        32'(0));
        check_eq("rst/red",     32'(light_red),    32'(4'hF));
        check_eq("rst/yellow",  32'(light_yellow), 32'(0));
        check_eq("rst/green",   32'(light_green),  32'(0));
        check_eq("rst/dec_en",  32'(dec_en),       32'(0));
        check_eq("rst/dec_sel", 32'(dec_sel),      32'(0));
        $display("reset: phase=%0d R=%b Y=%b G=%b", phase, light_red, light_yellow, light_green);
        m_state = 0; m_timer = 0; m_cur = 0; m_last = 3;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lane;
        hold_counts = 1'b0;
        m_cnt = '{2, 0, 1, 0};
        drive_counts();
        do_reset();

        // L0 twice, then L2 once, then ARB idles with all lanes empty.
        mode = MODE_SCHED;
        dec_seen = 0;
        for (int i = 0; i < 16; i++) do_tick("s1");
        check_eq("s1/dec_total", 32'(dec_seen), 32'(3));

        // L1 held at 9: green capped at GREEN_MAX ticks.
        hold_counts = 1'b1;
        m_cnt = '{0, 9, 0, 0};
        drive_counts();
        dec_seen = 0;
        g1_seen  = 0;
        for (int i = 0; i < 10; i++) do_tick("s2");
        check_eq("s2/green_ticks", 32'(g1_seen),  32'(GREEN_MAX));
        check_eq("s2/dec_total",   32'(dec_seen), 32'(GREEN_MAX));

        // All lanes empty: stays in ARB with no grant.
        m_cnt = '{0, 0, 0, 0};
        drive_counts();
        for (int i = 0; i < 8; i++) do_tick("s3a");
        dec_seen  = 0;
        any_green = 1'b0;
        for (int i = 0; i < 6; i++) do_tick("s3");
        check_eq("s3/dec_total", 32'(dec_seen),  32'(0));
        check_eq("s3/any_green", 32'(any_green), 32'(0));
        check_eq("s3/phase_arb", 32'(phase),     32'(ST_ARB));

        // Mode drops to all-red on the second green tick of L3.
        hold_counts = 1'b0;
        m_cnt = '{0, 0, 0, 5};
        drive_counts();
        for (int i = 0; i < 8 && m_state != 2; i++) do_tick("s4g");
        check_eq("s4/grant_l3", 32'(light_green), 32'(4'b1000));
        do_tick("s4g1");
        mode = MODE_RED;
        any_green = 1'b0;
        do_tick("s4y");
        check_eq("s4/yellow_l3", 32'(light_yellow), 32'(4'b1000));
        for (int i = 0; i < 6; i++) do_tick("s4r");
        check_eq("s4/any_green", 32'(any_green), 32'(0));
        check_eq("s4/hold_red",  32'(phase),     32'(ST_HOLD_RED));

        // Reset while in yellow, then first grant scans from L0.
        mode = MODE_SCHED;
        hold_counts = 1'b1;
        m_cnt = '{0, 3, 0, 2};
        drive_counts();
        for (int i = 0; i < 30 && m_state != 3; i++) do_tick("s5a");
        check_eq("s5/in_yellow", 32'(phase), 32'(ST_YELLOW));
        do_reset();
        exp_lane = 0;
        for (int i = 3; i >= 0; i--) if (m_cnt[i] != 0) exp_lane = i;
        for (int i = 0; i < 8 && m_state != 2; i++) do_tick("s5b");
        check_eq("s5/first_grant", 32'(light_green), 32'(1 << exp_lane));

        // Load mode and the aliased all-red encoding.
        do_reset();
        dec_seen  = 0;
        any_green = 1'b0;
        mode = MODE_LOAD;
        for (int i = 0; i < 10; i++) do_tick("s6m00");
        mode = 2'b11;
        for (int i = 0; i < 10; i++) do_tick("s6m11");
        check_eq("s6/dec_total", 32'(dec_seen),  32'(0));
        check_eq("s6/any_green", 32'(any_green), 32'(0));
        check_eq("s6/red_all",   32'(light_red), 32'(4'hF));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
